// File: rtl/bp_me_pkg.sv
// Shared types for the SAC tile I/O arbiter.
package bp_me_pkg;

    typedef enum logic {
        e_idle,
        e_send
    } bp_sac_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with occupancy count; holds requester IDs of in-flight commands.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 2,
    parameter int els_p   = 4,
    localparam int cnt_w  = $clog2(els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [cnt_w-1:0]   count_o
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;
    logic               push, pop;

    assign ready_o = (count_q != cnt_w'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == ptr_w'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == ptr_w'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the occupancy as it was.
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_sac_io_arbiter.sv
// Round-robin arbiter sharing one socket I/O command channel among requesters;
// responses are steered back in issue order via a tag FIFO of requester IDs.
module bp_sac_io_arbiter
    import bp_me_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int msg_width_p       = 512,
    parameter int max_outstanding_p = 4,
    localparam int cnt_w            = $clog2(max_outstanding_p + 1)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [num_req_p-1:0][msg_width_p-1:0]  req_cmd_i,
    input  logic [num_req_p-1:0]                   req_cmd_v_i,
    output logic [num_req_p-1:0]                   req_cmd_yumi_o,
    output logic [msg_width_p-1:0]                 req_resp_o,
    output logic [num_req_p-1:0]                   req_resp_v_o,
    input  logic [num_req_p-1:0]                   req_resp_ready_i,
    output logic [msg_width_p-1:0]                 io_cmd_o,
    output logic                                   io_cmd_v_o,
    input  logic                                   io_cmd_ready_i,
    input  logic [msg_width_p-1:0]                 io_resp_i,
    input  logic                                   io_resp_v_i,
    output logic                                   io_resp_yumi_o,
    output logic [cnt_w-1:0]                       outstanding_o,
    output logic                                   err_o
);

    localparam int id_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    bp_sac_arb_state_e      state_q, state_d;
    logic [msg_width_p-1:0] cmd_q, cmd_d;
    logic [id_w-1:0]        last_q, last_d;
    logic                   err_q, err_d;

    logic [id_w-1:0]        winner, cand;
    logic                   found, capture, credit_ok, slot_free;
    logic [id_w-1:0]        head_id;
    logic                   head_v;
    logic                   resp_pop;

    // Scan starting one past the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = id_w'((int'(last_q) + i) % num_req_p);
            if (!found && req_cmd_v_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign slot_free = (state_q == e_idle) || io_cmd_ready_i;
    assign capture   = found && credit_ok && slot_free;

    always_comb begin
        state_d        = state_q;
        cmd_d          = cmd_q;
        last_d         = last_q;
        req_cmd_yumi_o = '0;
        if (capture) begin
            state_d                = e_send;
            cmd_d                  = req_cmd_i[winner];
            last_d                 = winner;
            req_cmd_yumi_o[winner] = 1'b1;
        end else if (state_q == e_send && io_cmd_ready_i) begin
            state_d = e_idle;
        end
    end

    assign io_cmd_o   = cmd_q;
    assign io_cmd_v_o = (state_q == e_send);

    // Response path is purely combinational; the FIFO head names the owner.
    always_comb begin
        req_resp_v_o = '0;
        resp_pop     = io_resp_v_i && head_v && req_resp_ready_i[head_id];
        if (io_resp_v_i && head_v) begin
            req_resp_v_o[head_id] = 1'b1;
        end
        err_d = err_q | (io_resp_v_i & ~head_v);
    end

    assign req_resp_o     = io_resp_i;
    assign io_resp_yumi_o = resp_pop;
    assign err_o          = err_q;

    bsg_fifo_1r1w_small #(
        .width_p (id_w),
        .els_p   (max_outstanding_p)
    ) tag_fifo (
        .clk_i   (clk_i),
        .reset_i (~reset_n_i),
        .data_i  (winner),
        .v_i     (capture),
        .ready_o (credit_ok),
        .data_o  (head_id),
        .v_o     (head_v),
        .yumi_i  (resp_pop),
        .count_o (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            last_q  <= id_w'(num_req_p - 1);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cmd_q <= cmd_d;
    end

endmodule

// File: tb/tb_bp_sac_io_arbiter.sv
// Directed bench for bp_sac_io_arbiter: inputs change after the falling edge and
// outputs are sampled 1ns later, away from the rising edge.
module tb_bp_sac_io_arbiter;

    logic             clk;
    logic             reset_n;
    logic [3:0][511:0] req_cmd;
    logic [3:0]       req_cmd_v;
    logic [3:0]       req_cmd_yumi;
    logic [511:0]     req_resp;
    logic [3:0]       req_resp_v;
    logic [3:0]       req_resp_ready;
    logic [511:0]     io_cmd;
    logic             io_cmd_v;
    logic             io_cmd_ready;
    logic [511:0]     io_resp;
    logic             io_resp_v;
    logic             io_resp_yumi;
    logic [2:0]       outstanding;
    logic             err;

    int vec  = 0;
    int errs = 0;

    bp_sac_io_arbiter dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .req_cmd_i        (req_cmd),
        .req_cmd_v_i      (req_cmd_v),
        .req_cmd_yumi_o   (req_cmd_yumi),
        .req_resp_o       (req_resp),
        .req_resp_v_o     (req_resp_v),
        .req_resp_ready_i (req_resp_ready),
        .io_cmd_o         (io_cmd),
        .io_cmd_v_o       (io_cmd_v),
        .io_cmd_ready_i   (io_cmd_ready),
        .io_resp_i        (io_resp),
        .io_resp_v_i      (io_resp_v),
        .io_resp_yumi_o   (io_resp_yumi),
        .outstanding_o    (outstanding),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_cmd_v      = '0;
        req_resp_ready = 4'hF;
        io_cmd_ready   = 1'b1;
        io_resp_v      = 1'b0;
        io_resp        = '0;
    endtask

    task automatic do_reset();
        cyc();
        idle_inputs();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_cmd = '0;
        do_reset();
        #1;
        vec++; if (io_cmd_v !== 1'b0) begin errs++; $display("FAIL reset_cmd_v: got %b want 0", io_cmd_v); end
        vec++; if (outstanding !== 3'd0) begin errs++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err); end
        vec++; if (req_cmd_yumi !== 4'b0000) begin errs++; $display("FAIL reset_yumi: got %b want 0000", req_cmd_yumi); end
        vec++; if (req_resp_v !== 4'b0000 || io_resp_yumi !== 1'b0) begin
            errs++; $display("FAIL reset_resp: got v=%b yumi=%b want 0000/0", req_resp_v, io_resp_yumi);
        end
    endtask

    task automatic test_single();
        cyc();
        req_cmd[2] = 512'hA5;
        req_cmd_v  = 4'b0100;
        #1;
        vec++; if (req_cmd_yumi !== 4'b0100) begin errs++; $display("FAIL single_yumi: got %b want 0100", req_cmd_yumi); end
        cyc();
        req_cmd_v    = '0;
        io_cmd_ready = 1'b0;
        #1;
        vec++; if (io_cmd_v !== 1'b1 || io_cmd !== 512'hA5) begin
            errs++; $display("FAIL single_cmd: got v=%b cmd=%0h want 1/a5", io_cmd_v, io_cmd);
        end
        vec++; if (outstanding !== 3'd1) begin errs++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
        cyc();
        io_cmd_ready = 1'b1;
        #1;
        vec++; if (io_cmd_v !== 1'b1) begin errs++; $display("FAIL single_hold: got %b want 1", io_cmd_v); end
        cyc();
        io_resp_v = 1'b1;
        io_resp   = 512'h5A;
        #1;
        vec++; if (io_cmd_v !== 1'b0) begin errs++; $display("FAIL single_drop: got %b want 0", io_cmd_v); end
        vec++; if (req_resp_v !== 4'b0100 || io_resp_yumi !== 1'b1 || req_resp !== 512'h5A) begin
            errs++; $display("FAIL single_resp: got v=%b yumi=%b data=%0h want 0100/1/5a", req_resp_v, io_resp_yumi, req_resp);
        end
        cyc();
        io_resp_v = 1'b0;
        #1;
        vec++; if (outstanding !== 3'd0) begin errs++; $display("FAIL single_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_yumi [5];
        logic [1:0] exp_id   [5];
        exp_yumi = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) req_cmd[i] = 512'h10 + 512'(i);
        for (int k = 0; k < 5; k++) begin
            cyc();
            req_cmd_v = 4'hF;
            io_resp_v = (k > 0);
            io_resp   = 512'h100 + 512'(k);
            #1;
            vec++; if (req_cmd_yumi !== exp_yumi[k]) begin
                errs++; $display("FAIL b2b_yumi[%0d]: got %b want %b", k, req_cmd_yumi, exp_yumi[k]);
            end
            if (k > 0) begin
                vec++; if (io_cmd_v !== 1'b1 || io_cmd !== 512'h10 + 512'(exp_id[k-1])) begin
                    errs++; $display("FAIL b2b_cmd[%0d]: got v=%b cmd=%0h want 1/%0h", k, io_cmd_v, io_cmd, 512'h10 + 512'(exp_id[k-1]));
                end
                vec++; if (req_resp_v !== exp_yumi[k-1] || io_resp_yumi !== 1'b1) begin
                    errs++; $display("FAIL b2b_resp[%0d]: got v=%b yumi=%b want %b/1", k, req_resp_v, io_resp_yumi, exp_yumi[k-1]);
                end
            end
        end
        cyc();
        req_cmd_v = '0;
        #1;
        vec++; if (io_cmd !== 512'h10 || req_resp_v !== 4'b0001) begin
            errs++; $display("FAIL b2b_last: got cmd=%0h v=%b want 10/0001", io_cmd, req_resp_v);
        end
        cyc();
        io_resp_v = 1'b0;
        #1;
        vec++; if (outstanding !== 3'd0 || io_cmd_v !== 1'b0 || err !== 1'b0) begin
            errs++; $display("FAIL b2b_drain: got out=%0d v=%b err=%b want 0/0/0", outstanding, io_cmd_v, err);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_cmd[1] = 512'hB1;
        req_cmd[3] = 512'hB3;
        cyc();
        req_cmd_v    = 4'b0010;
        io_cmd_ready = 1'b0;
        #1;
        vec++; if (req_cmd_yumi !== 4'b0010) begin errs++; $display("FAIL bp_first_yumi: got %b want 0010", req_cmd_yumi); end
        for (int k = 0; k < 5; k++) begin
            cyc();
            req_cmd_v = 4'b1000;
            #1;
            vec++; if (io_cmd_v !== 1'b1 || io_cmd !== 512'hB1 || req_cmd_yumi !== 4'b0000) begin
                errs++; $display("FAIL bp_stall[%0d]: got v=%b cmd=%0h yumi=%b want 1/b1/0000", k, io_cmd_v, io_cmd, req_cmd_yumi);
            end
        end
        cyc();
        io_cmd_ready = 1'b1;
        #1;
        vec++; if (req_cmd_yumi !== 4'b1000) begin errs++; $display("FAIL bp_resume: got %b want 1000", req_cmd_yumi); end
        cyc();
        req_cmd_v = '0;
        #1;
        vec++; if (io_cmd_v !== 1'b1 || io_cmd !== 512'hB3 || outstanding !== 3'd2) begin
            errs++; $display("FAIL bp_next: got v=%b cmd=%0h out=%0d want 1/b3/2", io_cmd_v, io_cmd, outstanding);
        end
    endtask

    task automatic test_resp_backpressure();
        for (int k = 0; k < 3; k++) begin
            cyc();
            io_resp_v      = 1'b1;
            io_resp        = 512'hC1;
            req_resp_ready = 4'b1101;
            #1;
            vec++; if (io_resp_yumi !== 1'b0 || req_resp_v !== 4'b0010) begin
                errs++; $display("FAIL rbp_stall[%0d]: got yumi=%b v=%b want 0/0010", k, io_resp_yumi, req_resp_v);
            end
        end
        cyc();
        req_resp_ready = 4'hF;
        #1;
        vec++; if (io_resp_yumi !== 1'b1 || req_resp_v !== 4'b0010) begin
            errs++; $display("FAIL rbp_pop: got yumi=%b v=%b want 1/0010", io_resp_yumi, req_resp_v);
        end
        cyc();
        #1;
        vec++; if (io_resp_yumi !== 1'b1 || req_resp_v !== 4'b1000 || outstanding !== 3'd1) begin
            errs++; $display("FAIL rbp_second: got yumi=%b v=%b out=%0d want 1/1000/1", io_resp_yumi, req_resp_v, outstanding);
        end
        cyc();
        io_resp_v = 1'b0;
        #1;
        vec++; if (outstanding !== 3'd0) begin errs++; $display("FAIL rbp_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_credit();
        do_reset();
        req_cmd[0] = 512'hD0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            req_cmd_v = 4'b0001;
            #1;
            vec++; if (req_cmd_yumi !== 4'b0001) begin errs++; $display("FAIL credit_issue[%0d]: got %b want 0001", k, req_cmd_yumi); end
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            vec++; if (outstanding !== 3'd4 || req_cmd_yumi !== 4'b0000) begin
                errs++; $display("FAIL credit_full[%0d]: got out=%0d yumi=%b want 4/0000", k, outstanding, req_cmd_yumi);
            end
        end
        cyc();
        io_resp_v = 1'b1;
        #1;
        vec++; if (io_resp_yumi !== 1'b1 || req_cmd_yumi !== 4'b0000) begin
            errs++; $display("FAIL credit_pop: got ryumi=%b cyumi=%b want 1/0000", io_resp_yumi, req_cmd_yumi);
        end
        cyc();
        io_resp_v = 1'b0;
        #1;
        vec++; if (req_cmd_yumi !== 4'b0001 || outstanding !== 3'd3) begin
            errs++; $display("FAIL credit_refill: got yumi=%b out=%0d want 0001/3", req_cmd_yumi, outstanding);
        end
        cyc();
        req_cmd_v = '0;
        #1;
        vec++; if (outstanding !== 3'd4) begin errs++; $display("FAIL credit_refull: got %0d want 4", outstanding); end
    endtask

    task automatic test_err();
        do_reset();
        #1;
        vec++; if (outstanding !== 3'd0 || io_cmd_v !== 1'b0) begin
            errs++; $display("FAIL midreset: got out=%0d v=%b want 0/0", outstanding, io_cmd_v);
        end
        cyc();
        io_resp_v = 1'b1;
        io_resp   = 512'hEE;
        #1;
        vec++; if (io_resp_yumi !== 1'b0 || req_resp_v !== 4'b0000) begin
            errs++; $display("FAIL spur_resp: got yumi=%b v=%b want 0/0000", io_resp_yumi, req_resp_v);
        end
        cyc();
        io_resp_v = 1'b0;
        #1;
        vec++; if (err !== 1'b1) begin errs++; $display("FAIL spur_err: got %b want 1", err); end
        cyc();
        cyc();
        #1;
        vec++; if (err !== 1'b1) begin errs++; $display("FAIL spur_sticky: got %b want 1", err); end
        do_reset();
        #1;
        vec++; if (err !== 1'b0) begin errs++; $display("FAIL spur_clear: got %b want 0", err); end
    endtask

    initial begin
        reset_n = 1'b0;
        req_cmd = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_resp_backpressure();
        test_credit();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
